// File: rtl/guess_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : guess_engine_if                                            |
// | Description : Control and status bundle of the number-guessing engine.   |
// |               master = game controller / stimulus side,                  |
// |               slave  = guess_engine.                                     |
// | Signals     : start, seed_we, seed_val[31:0], digit_we, digit_sel[2:0],  |
// |               digit_val[3:0], submit           (master -> slave)         |
// |               state[2:0], guess_bcd[4*DIGITS-1:0], time_bcd[7:0],        |
// |               tries_left[3:0], hi, lo, win, lose, bulls[3:0]             |
// |                                                (slave -> master)         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface guess_engine_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic                  seed_we;
   logic [31:0]           seed_val;
   logic                  digit_we;
   logic [2:0]            digit_sel;
   logic [3:0]            digit_val;
   logic                  submit;
   logic [2:0]            state;
   logic [4*DIGITS-1:0]   guess_bcd;
   logic [7:0]            time_bcd;
   logic [3:0]            tries_left;
   logic                  hi;
   logic                  lo;
   logic                  win;
   logic                  lose;
   logic [3:0]            bulls;

   modport master (
      output start, seed_we, seed_val, digit_we, digit_sel, digit_val, submit,
      input  state, guess_bcd, time_bcd, tries_left, hi, lo, win, lose, bulls
   );

   modport slave (
      input  start, seed_we, seed_val, digit_we, digit_sel, digit_val, submit,
      output state, guess_bcd, time_bcd, tries_left, hi, lo, win, lose, bulls
   );
endinterface
`default_nettype wire

// File: rtl/guess_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : guess_engine                                               |
// | Description : Number-guessing game core. Draws a DIGITS-digit BCD secret |
// |               from a free-running Galois LFSR, accepts digit-wise        |
// |               guesses, reports higher/lower, runs a seconds countdown    |
// |               and an attempt limit.                                      |
// | Ports       : CLK  - clock, all logic on posedge                         |
// |               RST  - synchronous active-high reset                       |
// |               bus  - guess_engine_if.slave (inputs start, seed_we,       |
// |                      seed_val, digit_we, digit_sel, digit_val, submit;   |
// |                      outputs state, guess_bcd, time_bcd, tries_left,     |
// |                      hi, lo, win, lose, bulls)                           |
// | Option      : define GUESS_BULLS_EN to count digits correct in position; |
// |               otherwise bulls is constant 0.                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module guess_engine #(
   parameter int DIGITS        = 4,
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int TIME_LIMIT    = 99,
   parameter int MAX_TRIES     = 8
) (
   input  logic          CLK,
   input  logic          RST,
   guess_engine_if.slave bus
);

   localparam logic [2:0]      c_IDLE     = 3'd0;
   localparam logic [2:0]      c_PLAY     = 3'd1;
   localparam logic [2:0]      c_CHECK    = 3'd2;
   localparam logic [2:0]      c_WIN      = 3'd3;
   localparam logic [2:0]      c_LOSE     = 3'd4;
   localparam int              c_GW       = 4 * DIGITS;
   localparam int              c_PW       = $clog2(TICKS_PER_SEC);
   localparam logic [c_PW-1:0] c_PMAX     = c_PW'(TICKS_PER_SEC - 1);
   localparam logic [7:0]      c_TIME_BCD = {4'(TIME_LIMIT / 10), 4'(TIME_LIMIT % 10)};
   localparam logic [3:0]      c_TRIES    = 4'(MAX_TRIES);
   // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
   localparam logic [31:0]     c_TAPS     = 32'h8020_0003;

   logic [2:0]      state_q,  state_d;
   logic [31:0]     lfsr_q,   lfsr_d;
   logic [c_GW-1:0] secret_q, secret_d;
   logic [c_GW-1:0] guess_q,  guess_d;
   logic [7:0]      time_q,   time_d;
   logic [c_PW-1:0] presc_q,  presc_d;
   logic [3:0]      tries_q,  tries_d;
   logic            hi_q,     hi_d;
   logic            lo_q,     lo_d;

   logic            w_reload;
   logic            w_run;
   logic            w_tick;
   logic [c_GW-1:0] w_new_secret;

   assign w_reload = bus.start &&
                     (state_q == c_IDLE || state_q == c_WIN || state_q == c_LOSE);
   assign w_run    = (state_q == c_PLAY) || (state_q == c_CHECK);
   assign w_tick   = (presc_q == c_PMAX);

   // LFSR nibbles 10..15 fold onto 4..9 so every secret digit is valid BCD.
   always_comb begin : p_secret
      logic [3:0] nib;
      w_new_secret = '0;
      for (int i = 0; i < DIGITS; i++) begin
         nib = lfsr_q[4*i +: 4];
         w_new_secret[4*i +: 4] = (nib > 4'd9) ? (nib - 4'd6) : nib;
      end
   end

   always_comb begin
      state_d  = state_q;
      secret_d = secret_q;
      guess_d  = guess_q;
      time_d   = time_q;
      presc_d  = presc_q;
      tries_d  = tries_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      if (state_q == c_IDLE && bus.seed_we)
         lfsr_d = (bus.seed_val == 32'd0) ? 32'd1 : bus.seed_val;
      else
         lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? c_TAPS : 32'd0);

      // Seconds countdown; holds at 00 once reached.
      if (w_run) begin
         presc_d = w_tick ? '0 : presc_q + c_PW'(1);
         if (w_tick && time_q != 8'h00) begin
            if (time_q[3:0] == 4'd0)
               time_d = {time_q[7:4] - 4'd1, 4'd9};
            else
               time_d = {time_q[7:4], time_q[3:0] - 4'd1};
         end
      end

      case (state_q)
         c_IDLE, c_WIN, c_LOSE: begin
            if (w_reload) begin
               state_d  = c_PLAY;
               secret_d = w_new_secret;
               guess_d  = '0;
               time_d   = c_TIME_BCD;
               presc_d  = '0;
               tries_d  = c_TRIES;
               hi_d     = 1'b0;
               lo_d     = 1'b0;
            end
         end
         c_PLAY: begin
            // A submit in the cycle the clock shows 00 still gets its compare.
            if (bus.submit) begin
               state_d = c_CHECK;
            end else if (time_q == 8'h00) begin
               state_d = c_LOSE;
            end else if (bus.digit_we && bus.digit_val <= 4'd9) begin
               // Indices at or above DIGITS match no loop iteration and drop out.
               for (int i = 0; i < DIGITS; i++) begin
                  if (bus.digit_sel == 3'(i))
                     guess_d[4*i +: 4] = bus.digit_val;
               end
            end
         end
         c_CHECK: begin
            // All digits are <= 9, so a plain unsigned compare is numeric order.
            if (guess_q == secret_q) begin
               state_d = c_WIN;
               hi_d    = 1'b0;
               lo_d    = 1'b0;
            end else begin
               hi_d    = (guess_q > secret_q);
               lo_d    = !(guess_q > secret_q);
               tries_d = tries_q - 4'd1;
               state_d = (tries_q == 4'd1 || time_q == 8'h00) ? c_LOSE : c_PLAY;
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= c_IDLE;
         lfsr_q   <= 32'd1;
         secret_q <= '0;
         guess_q  <= '0;
         time_q   <= c_TIME_BCD;
         presc_q  <= '0;
         tries_q  <= c_TRIES;
         hi_q     <= 1'b0;
         lo_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         secret_q <= secret_d;
         guess_q  <= guess_d;
         time_q   <= time_d;
         presc_q  <= presc_d;
         tries_q  <= tries_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

`ifdef GUESS_BULLS_EN
   logic [3:0] bulls_q, bulls_d;

   always_comb begin
      bulls_d = bulls_q;
      if (state_q == c_CHECK) begin
         bulls_d = 4'd0;
         for (int i = 0; i < DIGITS; i++) begin
            if (guess_q[4*i +: 4] == secret_q[4*i +: 4])
               bulls_d = bulls_d + 4'd1;
         end
      end else if (w_reload) begin
         bulls_d = 4'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST)
         bulls_q <= 4'd0;
      else
         bulls_q <= bulls_d;
   end

   assign bus.bulls = bulls_q;
`else
   assign bus.bulls = 4'd0;
`endif

   assign bus.state      = state_q;
   assign bus.guess_bcd  = guess_q;
   assign bus.time_bcd   = time_q;
   assign bus.tries_left = tries_q;
   assign bus.hi         = hi_q;
   assign bus.lo         = lo_q;
   assign bus.win        = (state_q == c_WIN);
   assign bus.lose       = (state_q == c_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_guess_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_guess_engine                                            |
// | Description : Self-checking bench for guess_engine. A cycle-level game   |
// |               model (integer digits, seconds and tries) predicts every   |
// |               output each cycle; directed scenarios are followed by a    |
// |               randomized run.                                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_guess_engine;
   localparam int DIGITS = 4;
   localparam int TPS    = 4;
   localparam int TL     = 12;
   localparam int MT     = 3;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   guess_engine_if #(.DIGITS(DIGITS)) bus ();

   guess_engine #(
      .DIGITS(DIGITS), .TICKS_PER_SEC(TPS), .TIME_LIMIT(TL), .MAX_TRIES(MT)
   ) dut (
      .CLK(CLK), .RST(RST), .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   int        m_state;          // 0 idle, 1 play, 2 check, 3 win, 4 lose
   int        m_secret[DIGITS];
   int        m_guess[DIGITS];
   int        m_sec;
   int        m_presc;
   int        m_tries;
   int        m_bulls;
   bit        m_hi, m_lo;
   bit [31:0] m_lfsr;

   function automatic bit [31:0] lfsr_next(input bit [31:0] s);
      bit fb;
      fb = s[0];
      s  = s >> 1;
      if (fb) s = s ^ 32'h8020_0003;
      return s;
   endfunction

   function automatic longint num_of(input int d[DIGITS]);
      longint v = 0;
      for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + d[i];
      return v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_sec = TL; m_presc = 0; m_tries = MT; m_bulls = 0;
      m_hi = 0; m_lo = 0; m_lfsr = 32'd1;
      for (int i = 0; i < DIGITS; i++) begin m_secret[i] = 0; m_guess[i] = 0; end
   endtask

   task automatic model_step();
      int        st, old_sec, nib;
      bit [31:0] old_lfsr;
      longint    g, s;
      if (RST) begin model_reset(); return; end
      st = m_state; old_sec = m_sec; old_lfsr = m_lfsr;
      if (st == 0 && bus.seed_we)
         m_lfsr = (bus.seed_val == 32'd0) ? 32'd1 : bus.seed_val;
      else
         m_lfsr = lfsr_next(m_lfsr);
      if (st == 1 || st == 2) begin
         if (m_presc == TPS - 1) begin
            m_presc = 0;
            if (m_sec > 0) m_sec = m_sec - 1;
         end else begin
            m_presc = m_presc + 1;
         end
      end
      case (st)
         0, 3, 4: if (bus.start) begin
            for (int i = 0; i < DIGITS; i++) begin
               nib = int'((old_lfsr >> (4 * i)) & 32'hF);
               m_secret[i] = (nib > 9) ? nib - 6 : nib;
               m_guess[i]  = 0;
            end
            m_sec = TL; m_presc = 0; m_tries = MT;
            m_hi = 0; m_lo = 0; m_bulls = 0; m_state = 1;
         end
         1: begin
            if (bus.submit) m_state = 2;
            else if (old_sec == 0) m_state = 4;
            else if (bus.digit_we && bus.digit_val <= 4'd9 && int'(bus.digit_sel) < DIGITS)
               m_guess[int'(bus.digit_sel)] = int'(bus.digit_val);
         end
         2: begin
            g = num_of(m_guess); s = num_of(m_secret);
`ifdef GUESS_BULLS_EN
            m_bulls = 0;
            for (int i = 0; i < DIGITS; i++) if (m_guess[i] == m_secret[i]) m_bulls++;
`endif
            if (g == s) begin
               m_state = 3; m_hi = 0; m_lo = 0;
            end else begin
               m_hi = (g > s); m_lo = !(g > s); m_tries = m_tries - 1;
               m_state = (m_tries == 0 || old_sec == 0) ? 4 : 1;
            end
         end
         default: ;
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] eg;
      eg = '0;
      for (int i = 0; i < DIGITS; i++) eg[4*i +: 4] = 4'(m_guess[i]);
      chk("state", 32'(bus.state), 32'(m_state));
      chk("guess_bcd", 32'(bus.guess_bcd), eg);
      chk("time_bcd", 32'(bus.time_bcd), {24'd0, 4'(m_sec / 10), 4'(m_sec % 10)});
      chk("tries_left", 32'(bus.tries_left), 32'(m_tries));
      chk("hi", 32'(bus.hi), 32'(m_hi));
      chk("lo", 32'(bus.lo), 32'(m_lo));
      chk("win", 32'(bus.win), 32'(m_state == 3));
      chk("lose", 32'(bus.lose), 32'(m_state == 4));
      chk("bulls", 32'(bus.bulls), 32'(m_bulls));
   endtask

   task automatic idle_inputs();
      bus.start = 0; bus.seed_we = 0; bus.seed_val = '0; bus.digit_we = 0;
      bus.digit_sel = '0; bus.digit_val = '0; bus.submit = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
      check_all();
      idle_inputs();
   endtask

   task automatic write_digit(input int sel, input int val);
      bus.digit_we = 1; bus.digit_sel = 3'(sel); bus.digit_val = 4'(val);
      tick();
   endtask

   task automatic enter(input int d0, input int d1, input int d2, input int d3);
      write_digit(0, d0); write_digit(1, d1); write_digit(2, d2); write_digit(3, d3);
   endtask

   task automatic submit_resolve();
      bus.submit = 1;
      tick();
      chk("submit_to_check", 32'(bus.state), 32'd2);
      tick();
   endtask

   int saved_sec;
   int sel;

   initial begin
      idle_inputs();
      model_reset();

      // Reset values
      RST = 1; tick(); tick();
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_time", 32'(bus.time_bcd), 32'h12);
      chk("rst_tries", 32'(bus.tries_left), 32'(MT));
      chk("rst_guess", 32'(bus.guess_bcd), 32'd0);
      RST = 0;

      // Seed and start: secret digits 0..3 = 8,7,6,5
      bus.seed_we = 1; bus.seed_val = 32'h1234_5678; tick();
      bus.start = 1; tick();
      chk("start_state", 32'(bus.state), 32'd1);
      chk("start_time", 32'(bus.time_bcd), 32'h12);

      enter(5, 5, 5, 5);
      submit_resolve();
      chk("low_hi", 32'(bus.hi), 32'd0);
      chk("low_lo", 32'(bus.lo), 32'd1);
      chk("low_tries", 32'(bus.tries_left), 32'(MT - 1));
      chk("low_back_play", 32'(bus.state), 32'd1);

      enter(8, 7, 1, 5);
      submit_resolve();
`ifdef GUESS_BULLS_EN
      chk("bulls_three", 32'(bus.bulls), 32'd3);
`else
      chk("bulls_off", 32'(bus.bulls), 32'd0);
`endif
      chk("near_lo", 32'(bus.lo), 32'd1);

      enter(8, 7, 6, 5);
      submit_resolve();
      chk("win_level", 32'(bus.win), 32'd1);
      chk("win_state", 32'(bus.state), 32'd3);
      chk("win_hilo", {30'd0, bus.hi, bus.lo}, 32'd0);
      saved_sec = m_sec;
      repeat (8) tick();
      chk("win_frozen", 32'(bus.time_bcd), {24'd0, 4'(saved_sec / 10), 4'(saved_sec % 10)});

      // Lose on the attempt limit
      bus.start = 1; tick();
      enter((m_secret[0] + 1) % 10, m_secret[1], m_secret[2], m_secret[3]);
      for (int k = 0; k < MT; k++) submit_resolve();
      chk("tries_state", 32'(bus.state), 32'd4);
      chk("tries_lose", 32'(bus.lose), 32'd1);
      chk("tries_zero", 32'(bus.tries_left), 32'd0);

      // Countdown and timeout
      bus.start = 1; tick();
      repeat (4) tick();
      chk("time_11", 32'(bus.time_bcd), 32'h11);
      repeat (8) tick();
      chk("time_09", 32'(bus.time_bcd), 32'h09);
      repeat (36) tick();
      chk("time_00", 32'(bus.time_bcd), 32'h00);
      chk("time_00_play", 32'(bus.state), 32'd1);
      tick();
      chk("timeout_lose", 32'(bus.lose), 32'd1);

      // Ignored writes, write/submit collision, start in PLAY, reset mid-round
      bus.start = 1; tick();
      write_digit(0, 3);
      chk("digit_ok", 32'(bus.guess_bcd), 32'h0003);
      write_digit(1, 12);
      chk("digit_bad_val", 32'(bus.guess_bcd), 32'h0003);
      write_digit(5, 2);
      chk("digit_bad_sel", 32'(bus.guess_bcd), 32'h0003);
      bus.digit_we = 1; bus.digit_sel = 3'd1; bus.digit_val = 4'd4; bus.submit = 1;
      tick();
      chk("collide_state", 32'(bus.state), 32'd2);
      chk("collide_guess", 32'(bus.guess_bcd), 32'h0003);
      tick();
      bus.start = 1; bus.seed_we = 1; bus.seed_val = 32'hDEAD_BEEF; tick();
      write_digit(2, 9);
      RST = 1; tick(); RST = 0;
      chk("rstmid_state", 32'(bus.state), 32'd0);
      chk("rstmid_guess", 32'(bus.guess_bcd), 32'd0);
      chk("rstmid_time", 32'(bus.time_bcd), 32'h12);
      chk("rstmid_tries", 32'(bus.tries_left), 32'(MT));

      // Correct submit in the cycle the clock reaches 00 still wins
      bus.start = 1; tick();
      enter(m_secret[0], m_secret[1], m_secret[2], m_secret[3]);
      for (int k = 0; k < 60 && m_sec != 0; k++) tick();
      chk("edge_time_00", 32'(bus.time_bcd), 32'h00);
      submit_resolve();
      chk("edge_win", 32'(bus.win), 32'd1);

      // Randomized play
      for (int n = 0; n < 3000; n++) begin
         RST           = ($urandom_range(0, 499) == 0);
         bus.start     = ($urandom_range(0, 99) < 3);
         bus.seed_we   = ($urandom_range(0, 19) == 0);
         bus.seed_val  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
         bus.digit_we  = ($urandom_range(0, 2) == 0);
         sel           = int'($urandom_range(0, 7));
         bus.digit_sel = 3'(sel);
         bus.digit_val = ($urandom_range(0, 1) == 1) ? 4'(m_secret[sel % DIGITS])
                                                     : 4'($urandom_range(0, 15));
         bus.submit    = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
